// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer and its jump table.
package pc_seq_pkg;

   localparam int unsigned PC_W_DEF  = 9;
   localparam int unsigned RUN_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } pc_state_t;

   typedef struct packed {
      logic                vld;
      logic [PC_W_DEF-1:0] src;
      logic [PC_W_DEF-1:0] off;
   } pc_entry_t;

endpackage

// File: rtl/pc_jump_table.sv
// Runtime-programmable jump table: per-entry {vld, src, off}, lowest-index match wins,
// and the jump target pc+off is formed here.
module pc_jump_table
   import pc_seq_pkg::*;
#(
   parameter int unsigned D     = PC_W_DEF,
   parameter int unsigned N_JMP = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(N_JMP)-1:0] idx,
   input  logic                     vld,
   input  logic [D-1:0]             src,
   input  logic [D-1:0]             off,
   input  logic [D-1:0]             pc,
   output logic                     hit,
   output logic [D-1:0]             target
);

   logic [N_JMP-1:0] vld_q;
   logic [D-1:0]     src_q [N_JMP];
   logic [D-1:0]     off_q [N_JMP];
   logic [D-1:0]     off_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < int'(N_JMP); i++) begin
            src_q[i] <= '0;
            off_q[i] <= '0;
         end
      end else if (we) begin
         vld_q[idx] <= vld;
         src_q[idx] <= src;
         off_q[idx] <= off;
      end
   end

   // Scan from the top down so the lowest matching index is the last to assign.
   always_comb begin
      hit     = 1'b0;
      off_sel = '0;
      for (int i = int'(N_JMP) - 1; i >= 0; i--) begin
         if (vld_q[i] && (src_q[i] == pc)) begin
            hit     = 1'b1;
            off_sel = off_q[i];
         end
      end
   end

   assign target = pc + off_sel;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: start/halt/fault control, sequential and table-driven jumps.
// Optional run-cycle counter built only when PC_SEQ_CYCLE_CNT_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned D     = PC_W_DEF,
   parameter int unsigned N_JMP = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [D-1:0]             start_addr,
   input  logic                     stall,
   input  logic                     jump,
   input  logic                     halt_in,
   input  logic                     cfg_we,
   input  logic [$clog2(N_JMP)-1:0] cfg_idx,
   input  logic                     cfg_vld,
   input  logic [D-1:0]             cfg_src,
   input  logic [D-1:0]             cfg_off,
   output logic [D-1:0]             pc,
   output logic                     pc_valid,
   output logic                     done,
   output logic                     fault,
   output logic [RUN_CNT_W-1:0]     run_cycles
);

   pc_state_t    state_q, state_d;
   logic [D-1:0] pc_q, pc_d;
   logic         hit;
   logic [D-1:0] target;
   logic         running;

   assign running = (state_q == RUN);

   pc_jump_table #(
      .D     (D),
      .N_JMP (N_JMP)
   ) u_jump_table (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (cfg_we && !running),
      .idx    (cfg_idx),
      .vld    (cfg_vld),
      .src    (cfg_src),
      .off    (cfg_off),
      .pc     (pc_q),
      .hit    (hit),
      .target (target)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      unique case (state_q)
         RUN: begin
            if (!stall) begin
               if (halt_in) begin
                  state_d = HALT;
               end else if (jump) begin
                  if (hit) pc_d = target;
                  else     state_d = FAULT;
               end else begin
                  pc_d = pc_q + 1'b1;
               end
            end
         end
         IDLE, HALT, FAULT: begin
            if (start) begin
               state_d = RUN;
               pc_d    = start_addr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign pc       = pc_q;
   assign pc_valid = running;
   assign done     = (state_q == HALT);
   assign fault    = (state_q == FAULT);

`ifdef PC_SEQ_CYCLE_CNT_EN
   logic [RUN_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!running && start) begin
         cnt_d = '0;
      end else if (running && !stall && (cnt_q != {RUN_CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign run_cycles = cnt_q;
`else
   assign run_cycles = '0;
`endif

endmodule
